// File: rtl/core_sequencer_if.sv
// core_sequencer_if: run/decoder/memory-handshake and status bundle for core_sequencer.
// master = sequencer side, slave = environment (memory, decoder, debug).
interface core_sequencer_if;
    logic        run;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic        dec_halt;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ifetch;
    logic        ir_load;
    logic        pc_write;
    logic        rf_write;
    logic        halted;
    logic        fault;
    logic        busy;
    logic [2:0]  state;
    logic [31:0] instr_count;
    modport master (
        input  run, dec_mem_read, dec_mem_write, dec_reg_write, dec_halt, mem_ack,
        output mem_req, mem_we, mem_ifetch, ir_load, pc_write, rf_write,
               halted, fault, busy, state, instr_count
    );
    modport slave (
        output run, dec_mem_read, dec_mem_write, dec_reg_write, dec_halt, mem_ack,
        input  mem_req, mem_we, mem_ifetch, ir_load, pc_write, rf_write,
               halted, fault, busy, state, instr_count
    );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer with one shared memory port.
// Define SEQ_TIMEOUT_EN to build the memory wait counter that faults after TIMEOUT_CYCLES.
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             rst_n,
    core_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_instr_count;
    logic        w_retire, w_req, w_timeout, w_count;

    assign w_req = (r_state == S_FETCH) || (r_state == S_MEM);

`ifdef SEQ_TIMEOUT_EN
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    logic [W-1:0] r_wait;
    // The cycle that would bring the counter to the limit faults unless ack arrives in it
    assign w_timeout = w_req && !bus.mem_ack && (r_wait == W'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wait <= '0;
        else if (w_next != r_state)
            r_wait <= '0;
        else if (w_req && !bus.mem_ack)
            r_wait <= r_wait + 1'b1;
    end
    assign bus.fault = (r_state == S_FAULT);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES[0];
    assign w_timeout = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:   w_next = bus.run ? S_FETCH : S_IDLE;
            S_FETCH:  w_next = bus.mem_ack ? S_DECODE : (w_timeout ? S_FAULT : S_FETCH);
            S_DECODE: w_next = bus.dec_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                w_next   = (bus.dec_mem_read || bus.dec_mem_write) ? S_MEM :
                           (bus.dec_reg_write ? S_WB : S_EXEC);
                w_retire = !bus.dec_mem_read && !bus.dec_mem_write && !bus.dec_reg_write;
            end
            S_MEM: begin
                w_next   = bus.mem_ack ? (bus.dec_mem_read ? S_WB : S_MEM) :
                           (w_timeout ? S_FAULT : S_MEM);
                w_retire = bus.mem_ack && !bus.dec_mem_read;
            end
            S_WB:     w_retire = 1'b1;
            S_HALT:   w_next = bus.run ? S_HALT : S_IDLE;
            default:  w_next = S_FAULT;
        endcase
        if (w_retire)
            w_next = bus.run ? S_FETCH : S_IDLE;
    end

    // A halt counts as retired on entry to HALT, without moving the PC
    assign w_count = w_retire || (r_state == S_DECODE && bus.dec_halt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_count)
                r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign bus.mem_req     = w_req;
    assign bus.mem_ifetch  = (r_state == S_FETCH);
    assign bus.mem_we      = (r_state == S_MEM) && bus.dec_mem_write;
    assign bus.ir_load     = (r_state == S_FETCH) && bus.mem_ack;
    assign bus.pc_write    = w_retire;
    assign bus.rf_write    = (r_state == S_WB);
    assign bus.halted      = (r_state == S_HALT);
    assign bus.busy        = (r_state != S_IDLE) && (r_state != S_HALT) && (r_state != S_FAULT);
    assign bus.state       = r_state;
    assign bus.instr_count = r_instr_count;
endmodule
